// File: rtl/commutation_pkg.sv
// Shared types and helpers for the matrix-converter commutation controller.
package commutation_pkg;

    // Per-phase FSM states: idle, steady conduction, four commutation steps.
    typedef enum logic [2:0] {
        ST_OFF = 3'd0,
        ST_ON  = 3'd1,
        ST_S1  = 3'd2,
        ST_S2  = 3'd3,
        ST_S3  = 3'd4,
        ST_S4  = 3'd5
    } phase_state_e;

    // Load codes selecting the input line of a phase.
    localparam logic [1:0] CODE_A   = 2'b00;
    localparam logic [1:0] CODE_B   = 2'b01;
    localparam logic [1:0] CODE_C   = 2'b10;
    localparam logic [1:0] CODE_INV = 2'b11;

    // Per-phase gate field: [5:4] input a {fwd,rev}, [3:2] input b, [1:0] input c.
    localparam int unsigned FIELD_W = 6;
    localparam int unsigned CODE_W  = 2;

    // Places a {fwd,rev} device pair into the field slot of one input line.
    function automatic logic [FIELD_W-1:0] dev_mask(input logic [1:0] src,
                                                    input logic fwd,
                                                    input logic rev);
        logic [FIELD_W-1:0] m;
        m = '0;
        case (src)
            CODE_A:  m = {fwd, rev, 4'b0000};
            CODE_B:  m = {2'b00, fwd, rev, 2'b00};
            CODE_C:  m = {4'b0000, fwd, rev};
            default: m = '0;
        endcase
        return m;
    endfunction

    // Gate pattern for a phase; the conducting device is fwd when sg = 1, rev when sg = 0.
    function automatic logic [FIELD_W-1:0] step_pattern(input phase_state_e st,
                                                        input logic [1:0]   sel,
                                                        input logic [1:0]   tgt,
                                                        input logic         sg);
        logic [FIELD_W-1:0] p;
        p = '0;
        case (st)
            ST_ON:   p = dev_mask(sel, 1'b1, 1'b1);
            ST_S1:   p = dev_mask(sel, sg, ~sg);
            ST_S2:   p = dev_mask(sel, sg, ~sg) | dev_mask(tgt, sg, ~sg);
            ST_S3:   p = dev_mask(tgt, sg, ~sg);
            ST_S4:   p = dev_mask(tgt, 1'b1, 1'b1);
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/commutation_phase.sv
// One output phase: source-selection FSM with four-step commutation and dwell counter.
module commutation_phase
    import commutation_pkg::*;
#(
    parameter int unsigned STEP_CYC = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [CODE_W-1:0]  code,
    input  logic               sign,
    output logic [FIELD_W-1:0] pattern_c,
    output logic               busy_c,
    output logic               invalid_c
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYC - 1);

    phase_state_e      state_q, state_d;
    logic [CODE_W-1:0] sel_q, sel_d;
    logic [CODE_W-1:0] tgt_q, tgt_d;
    logic              sg_q, sg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              step_done;

    assign step_done = (cnt_q == LAST_CNT);

    // State, selection, frozen sign and dwell counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            sel_q   <= CODE_A;
            tgt_q   <= CODE_A;
            sg_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            tgt_q   <= tgt_d;
            sg_q    <= sg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the end of S4 re-evaluates the code so a pending change starts S1 at once.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        tgt_d     = tgt_q;
        sg_d      = sg_q;
        cnt_d     = cnt_q;
        invalid_c = 1'b0;
        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (code == CODE_INV) begin
                        invalid_c = 1'b1;
                    end else begin
                        state_d = ST_ON;
                        sel_d   = code;
                    end
                end
                ST_ON: begin
                    if (code == CODE_INV) begin
                        invalid_c = 1'b1;
                    end else if (code != sel_q) begin
                        tgt_d   = code;
                        sg_d    = sign;
                        cnt_d   = '0;
                        state_d = ST_S1;
                    end
                end
                ST_S1: begin
                    if (step_done) begin
                        cnt_d   = '0;
                        state_d = ST_S2;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_S2: begin
                    if (step_done) begin
                        cnt_d   = '0;
                        state_d = ST_S3;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_S3: begin
                    if (step_done) begin
                        cnt_d   = '0;
                        state_d = ST_S4;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_S4: begin
                    if (step_done) begin
                        cnt_d   = '0;
                        sel_d   = tgt_q;
                        state_d = ST_ON;
                        if (code == CODE_INV) begin
                            invalid_c = 1'b1;
                        end else if (code != tgt_q) begin
                            tgt_d   = code;
                            sg_d    = sign;
                            state_d = ST_S1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Gate pattern and busy flag decoded from the registered state.
    always_comb begin
        pattern_c = step_pattern(state_q, sel_q, tgt_q, sg_q);
        busy_c    = (state_q == ST_S1) || (state_q == ST_S2) ||
                    (state_q == ST_S3) || (state_q == ST_S4);
    end

endmodule

// File: rtl/commutation_ctrl.sv
// Matrix-converter switch driver: NPH phases, run enable, sticky fault/invalid flags, gated output register.
module commutation_ctrl
    import commutation_pkg::*;
#(
    parameter int unsigned NPH      = 3,
    parameter int unsigned STEP_CYC = 2,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 short,
    input  logic [NPH-1:0]       CurrentSign,
    input  logic [CODE_W*NPH-1:0] DesiredLoad,
    output logic [FIELD_W*NPH-1:0] Sout,
    output logic [NPH-1:0]       busy,
    output logic                 fault,
    output logic                 invalid_seen
);

    localparam int unsigned SOUT_W = FIELD_W * NPH;

    logic              en_q;
    logic [SOUT_W-1:0] pat_c;
    logic [NPH-1:0]    busy_c;
    logic [NPH-1:0]    inv_c;

    // Phase 0 sits in the most significant slot of every per-phase bus.
    for (genvar p = 0; p < NPH; p++) begin : g_phase
        localparam int unsigned IDX = NPH - 1 - p;
        commutation_phase #(
            .STEP_CYC (STEP_CYC),
            .CNT_W    (CNT_W)
        ) u_phase (
            .clk       (clk),
            .rst       (rst),
            .en        (en_q),
            .code      (DesiredLoad[CODE_W*IDX +: CODE_W]),
            .sign      (CurrentSign[IDX]),
            .pattern_c (pat_c[FIELD_W*IDX +: FIELD_W]),
            .busy_c    (busy_c[IDX]),
            .invalid_c (inv_c[IDX])
        );
    end

    // Run enable, sticky flags and the output register; a live or latched short forces all gates off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q         <= 1'b0;
            fault        <= 1'b0;
            invalid_seen <= 1'b0;
            busy         <= '0;
            Sout         <= '0;
        end else begin
            en_q         <= start;
            fault        <= fault | short;
            invalid_seen <= invalid_seen | (|inv_c);
            busy         <= busy_c;
            if (fault || short) begin
                Sout <= '0;
            end else begin
                Sout <= pat_c;
            end
        end
    end

endmodule

// File: tb/tb_commutation_ctrl.sv
// Self-checking bench: directed scenarios plus randomized segments against a cycle-level reference model.
module tb_commutation_ctrl;

    localparam int NPH      = 3;
    localparam int STEP_CYC = 2;
    localparam int CNT_W    = 4;
    localparam int COMM_CYC = 4 * STEP_CYC;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               short = 1'b0;
    logic [NPH-1:0]     CurrentSign = '0;
    logic [2*NPH-1:0]   DesiredLoad = '0;
    logic [6*NPH-1:0]   Sout;
    logic [NPH-1:0]     busy;
    logic               fault;
    logic               invalid_seen;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = off, 1 = on(sel), 2 = commutating sel->tgt, t = cycles elapsed.
    int  m_mode [NPH];
    int  m_sel  [NPH];
    int  m_tgt  [NPH];
    int  m_t    [NPH];
    bit  m_sg   [NPH];
    bit  m_en, m_fault, m_inv;
    logic [6*NPH-1:0] e_sout;
    logic [NPH-1:0]   e_busy;

    logic [5:0] seq_pos [4] = '{6'b100000, 6'b101000, 6'b001000, 6'b001100};
    logic [5:0] seq_neg [4] = '{6'b010000, 6'b010100, 6'b000100, 6'b001100};

    commutation_ctrl #(
        .NPH      (NPH),
        .STEP_CYC (STEP_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .short        (short),
        .CurrentSign  (CurrentSign),
        .DesiredLoad  (DesiredLoad),
        .Sout         (Sout),
        .busy         (busy),
        .fault        (fault),
        .invalid_seen (invalid_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Devices of input src (0=a,1=b,2=c) as a 6-bit field.
    function automatic logic [5:0] dev(input int src, input bit f, input bit r);
        logic [5:0] v;
        v = '0;
        v[5-2*src] = f;
        v[4-2*src] = r;
        return v;
    endfunction

    // Expected field: sel keeps its conducting device for steps 0-1, tgt gains conducting from step 1, both at step 3.
    function automatic logic [5:0] model_field(input int p);
        int  stp;
        bit  s;
        stp = m_t[p] / STEP_CYC;
        s   = m_sg[p];
        if (m_mode[p] == 0) return 6'b000000;
        if (m_mode[p] == 1) return dev(m_sel[p], 1'b1, 1'b1);
        return dev(m_sel[p], (stp < 2) && s, (stp < 2) && !s)
             | dev(m_tgt[p], (stp >= 1) && s, (stp >= 1) && !s)
             | dev(m_tgt[p], (stp == 3) && !s, (stp == 3) && s);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPH; p++) begin
            m_mode[p] = 0; m_sel[p] = 0; m_tgt[p] = 0; m_t[p] = 0; m_sg[p] = 1'b0;
        end
        m_en = 1'b0; m_fault = 1'b0; m_inv = 1'b0;
    endtask

    task automatic model_eval(input int p, input int code, input bit sg, output bit inv);
        inv = 1'b0;
        if (code == 3) inv = 1'b1;
        else if (code != m_sel[p]) begin
            m_mode[p] = 2; m_tgt[p] = code; m_sg[p] = sg; m_t[p] = 0;
        end
    endtask

    // One active edge of the model, using the inputs as they stand at that edge.
    task automatic model_clock();
        bit inv_any, inv;
        int code;
        bit sg;
        inv_any = 1'b0;
        for (int p = 0; p < NPH; p++) begin
            e_sout[6*(NPH-1-p) +: 6] = model_field(p);
            e_busy[NPH-1-p] = (m_mode[p] == 2);
        end
        if (m_fault || short) e_sout = '0;
        for (int p = 0; p < NPH; p++) begin
            code = int'(DesiredLoad[2*(NPH-1-p) +: 2]);
            sg   = CurrentSign[NPH-1-p];
            inv  = 1'b0;
            if (!m_en) begin
                m_mode[p] = 0;
            end else if (m_mode[p] == 0) begin
                if (code == 3) inv = 1'b1;
                else begin m_mode[p] = 1; m_sel[p] = code; end
            end else if (m_mode[p] == 1) begin
                model_eval(p, code, sg, inv);
            end else if (m_t[p] == COMM_CYC - 1) begin
                m_mode[p] = 1; m_sel[p] = m_tgt[p];
                model_eval(p, code, sg, inv);
            end else begin
                m_t[p]++;
            end
            inv_any |= inv;
        end
        m_fault = m_fault | short;
        m_inv   = m_inv | inv_any;
        m_en    = start;
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        chk("sout", 32'(Sout), 32'(e_sout));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("invalid_seen", 32'(invalid_seen), 32'(m_inv));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Asynchronous reset between edges: outputs must clear with no clock.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_sout", 32'(Sout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_invalid", 32'(invalid_seen), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();

        // Power up on input a on every phase.
        start = 1'b1; DesiredLoad = 6'b000000; CurrentSign = 3'b111;
        ticks(3);
        chk("on_a", 32'(Sout[17:12]), 32'(6'b110000));

        // Phase 0 a->b with positive current.
        DesiredLoad = 6'b010000;
        tick();
        chk("pre_s1", 32'(Sout[17:12]), 32'(6'b110000));
        for (int i = 0; i < COMM_CYC; i++) begin
            tick();
            chk("pos_seq", 32'(Sout[17:12]), 32'(seq_pos[i/STEP_CYC]));
            chk("pos_busy", 32'(busy[2]), 32'h1);
        end
        tick();
        chk("pos_done", 32'(Sout[17:12]), 32'(6'b001100));
        chk("pos_idle", 32'(busy[2]), 32'h0);

        // Back to a, then a->b with negative current; sign toggled mid-S2 is ignored.
        DesiredLoad = 6'b000000;
        ticks(COMM_CYC + 2);
        DesiredLoad = 6'b010000; CurrentSign = 3'b011;
        tick();
        for (int i = 0; i < COMM_CYC; i++) begin
            tick();
            chk("neg_seq", 32'(Sout[17:12]), 32'(seq_neg[i/STEP_CYC]));
            if (i == 2) CurrentSign = 3'b111;
        end
        tick();

        // Invalid code holds source and latches the flag.
        DesiredLoad = 6'b110000;
        ticks(5);
        chk("inv_hold", 32'(Sout[17:12]), 32'(6'b001100));
        chk("inv_flag", 32'(invalid_seen), 32'h1);
        DesiredLoad = 6'b010000;
        ticks(3);
        chk("inv_sticky", 32'(invalid_seen), 32'h1);

        // Reset mid-run, release with start low.
        do_reset();
        start = 1'b0;
        ticks(4);
        chk("off_after_rst", 32'(Sout), 32'h0);

        // Run drop during commutation on the last phase, then restart onto c.
        start = 1'b1; DesiredLoad = 6'b000000; CurrentSign = 3'b111;
        ticks(3);
        DesiredLoad = 6'b000001;
        ticks(6);
        start = 1'b0;
        ticks(3);
        chk("drop_field", 32'(Sout[5:0]), 32'h0);
        chk("drop_busy", 32'(busy[0]), 32'h0);
        start = 1'b1; DesiredLoad = 6'b000010;
        ticks(4);
        chk("restart_c", 32'(Sout[5:0]), 32'(6'b000011));

        // One-cycle short during S2 of phase 0.
        DesiredLoad = 6'b010010;
        ticks(4);
        short = 1'b1;
        tick();
        short = 1'b0;
        chk("short_sout", 32'(Sout), 32'h0);
        chk("short_fault", 32'(fault), 32'h1);
        for (int i = 0; i < 12; i++) begin
            start = (i % 3 != 0);
            DesiredLoad = 6'(i * 5);
            tick();
            chk("fault_hold", 32'(Sout), 32'h0);
        end

        // Randomized segments, each from reset.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 80; i++) begin
                start = ($urandom_range(0, 15) != 0);
                short = ($urandom_range(0, 199) == 0);
                CurrentSign = 3'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    for (int p = 0; p < NPH; p++) begin
                        logic [1:0] c;
                        c = 2'($urandom);
                        if (seg % 2 == 0 && c == 2'b11) c = 2'($urandom_range(0, 2));
                        DesiredLoad[2*p +: 2] = c;
                    end
                end
                tick();
            end
            short = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
